object_bounce_mover: RTL and testbench

- Moves one rectangular sprite across a SCREEN_W x SCREEN_H playfield and reports when the sprite touches a playfield edge.
- Combines the position-stepping function (objectTransition) with boundary detection (objectOutOfBound).
- A parent motion controller uses the edge flags to flip direction bits on a bounce, and to apply keyboard overrides.
- Runs in the system clock domain; steps are triggered by a slow, asynchronous move tick.

---
 rtl/object_pkg.sv | 11 +
 rtl/object_bounce_mover_if.sv | 34 +++
 rtl/object_bound_check.sv | 43 ++++
 rtl/object_bounce_mover.sv | 132 +++++++++++++
 tb/tb_object_bounce_mover.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/object_pkg.sv
// Shared constants for the bouncing-sprite mover: playfield size, coordinate
// widths and the bit positions inside the 2-bit direction words.
// No logic; imported by the interface, the top and the bound checker.
package object_pkg;
  localparam int SCREEN_W = 640;  // playfield width in pixels
  localparam int SCREEN_H = 480;  // playfield height in pixels
  localparam int X_W      = 10;   // x coordinate width
  localparam int Y_W      = 9;    // y coordinate width
  localparam int DIR_EN   = 1;    // direction word: motion enable bit
  localparam int DIR_SIGN = 0;    // direction word: 1 = +axis, 0 = -axis
endpackage

// File: rtl/object_bounce_mover_if.sv
// Bundle between a motion controller (master) and the sprite mover (slave).
// Latency: none, wires only.  Backpressure: none, the tick is fire-and-forget.
// Carries the move tick, velocities, directions, start position, sprite size,
// and the returned position and edge flags.
interface object_bounce_mover_if #(
  parameter int VEL_W = 4
);
  import object_pkg::*;

  logic             moveclk;
  logic [VEL_W-1:0] vx;
  logic [VEL_W-1:0] vy;
  logic [1:0]       dx;
  logic [1:0]       dy;
  logic [X_W-1:0]   initPosX;
  logic [Y_W-1:0]   initPosY;
  logic [X_W-1:0]   width;
  logic [Y_W-1:0]   height;
  logic [X_W-1:0]   posx;
  logic [Y_W-1:0]   posy;
  logic             flag_out;
  logic             flagx_out;
  logic             flagy_out;

  modport master (
    output moveclk, vx, vy, dx, dy, initPosX, initPosY, width, height,
    input  posx, posy, flag_out, flagx_out, flagy_out
  );

  modport slave (
    input  moveclk, vx, vy, dx, dy, initPosX, initPosY, width, height,
    output posx, posy, flag_out, flagx_out, flagy_out
  );
endinterface

// File: rtl/object_bound_check.sv
// Edge detector: flags a sprite whose top-left corner sits on 0 or at/over max.
// Latency: flags are registered, one clk after the position they describe.
// Backpressure: none.  Ports: clk, rst_n, upd_en_i, posx_i/posy_i, xmax_i/ymax_i -> flagx_o, flagy_o.
module object_bound_check
  import object_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           upd_en_i,
  input  logic [X_W-1:0] posx_i,
  input  logic [Y_W-1:0] posy_i,
  input  logic [X_W:0]   xmax_i,
  input  logic [Y_W:0]   ymax_i,
  output logic           flagx_o,
  output logic           flagy_o
);
  logic flagx_q, flagx_d;
  logic flagy_q, flagy_d;

  // Hold the flags while the start position has not been loaded yet, so the
  // reset position (0,0) never shows up as a one-cycle edge hit.
  always_comb begin
    flagx_d = flagx_q;
    flagy_d = flagy_q;
    if (upd_en_i) begin
      flagx_d = (posx_i == '0) || ({1'b0, posx_i} >= xmax_i);
      flagy_d = (posy_i == '0) || ({1'b0, posy_i} >= ymax_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flagx_q <= 1'b0;
      flagy_q <= 1'b0;
    end else begin
      flagx_q <= flagx_d;
      flagy_q <= flagy_d;
    end
  end

  assign flagx_o = flagx_q;
  assign flagy_o = flagy_q;
endmodule

// File: rtl/object_bounce_mover.sv
// Moves one sprite per rising edge of an asynchronous move tick, clamped to the playfield.
// Latency: step lands on the 3rd clk edge after the tick rises; flags one clk later.
// Backpressure: none; ports are clk, rst_n and the slave side of object_bounce_mover_if.
module object_bounce_mover #(
  parameter int SCREEN_W = object_pkg::SCREEN_W,
  parameter int SCREEN_H = object_pkg::SCREEN_H,
  parameter int VEL_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  object_bounce_mover_if.slave  bus
);
  import object_pkg::*;

  localparam logic [X_W:0] SW = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0] SH = (Y_W + 1)'(SCREEN_H);

  // ---------------- tick synchronizer ----------------
  logic       s1_q, s2_q, s3_q;
  logic [1:0] prime_q;
  logic       step;

  // prime_q marks when s2 carries a real sample. Until then s3 is forced high
  // so a tick already held high across reset release is not taken as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      prime_q <= 2'b00;
    end else begin
      s1_q    <= bus.moveclk;
      s2_q    <= s1_q;
      s3_q    <= prime_q[1] ? s2_q : 1'b1;
      prime_q <= {prime_q[0], 1'b1};
    end
  end

  logic init_pending_q;

  // The start-position load takes priority over a coincident step.
  assign step = s2_q & ~s3_q & ~init_pending_q;

  // ---------------- legal range ----------------
  logic [X_W:0] width_ext, xmax;
  logic [Y_W:0] height_ext, ymax;

  assign width_ext  = {1'b0, bus.width};
  assign height_ext = {1'b0, bus.height};
  assign xmax = (width_ext  >= SW) ? '0 : SW - width_ext;
  assign ymax = (height_ext >= SH) ? '0 : SH - height_ext;

  // ---------------- stepping ----------------
  logic [X_W-1:0] posx_q, posx_d;
  logic [Y_W-1:0] posy_q, posy_d;
  logic [X_W:0]   px, vxe, sumx, stepx, loadx, initx;
  logic [Y_W:0]   py, vye, sumy, stepy, loady, inity;

  assign px    = {1'b0, posx_q};
  assign py    = {1'b0, posy_q};
  assign vxe   = (X_W + 1)'(bus.vx);
  assign vye   = (Y_W + 1)'(bus.vy);
  assign sumx  = px + vxe;
  assign sumy  = py + vye;
  assign initx = {1'b0, bus.initPosX};
  assign inity = {1'b0, bus.initPosY};
  assign loadx = (initx > xmax) ? xmax : initx;
  assign loady = (inity > ymax) ? ymax : inity;

  // Zero velocity must hold explicitly: a sprite left beyond a shrunken max
  // would otherwise be pulled back by the min() even with v = 0.
  always_comb begin
    stepx = px;
    if (bus.dx[DIR_EN] && (bus.vx != VEL_W'(0))) begin
      if (bus.dx[DIR_SIGN]) stepx = (sumx > xmax) ? xmax : sumx;
      else                  stepx = (px < vxe) ? '0 : px - vxe;
    end
  end

  always_comb begin
    stepy = py;
    if (bus.dy[DIR_EN] && (bus.vy != VEL_W'(0))) begin
      if (bus.dy[DIR_SIGN]) stepy = (sumy > ymax) ? ymax : sumy;
      else                  stepy = (py < vye) ? '0 : py - vye;
    end
  end

  always_comb begin
    posx_d = posx_q;
    posy_d = posy_q;
    if (init_pending_q) begin
      posx_d = X_W'(loadx);
      posy_d = Y_W'(loady);
    end else if (step) begin
      posx_d = X_W'(stepx);
      posy_d = Y_W'(stepy);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      posx_q         <= '0;
      posy_q         <= '0;
      init_pending_q <= 1'b1;
    end else begin
      posx_q         <= posx_d;
      posy_q         <= posy_d;
      init_pending_q <= 1'b0;
    end
  end

  // ---------------- edge flags ----------------
  logic flagx, flagy;

  object_bound_check u_bound (
    .clk      (clk),
    .rst_n    (rst_n),
    .upd_en_i (~init_pending_q),
    .posx_i   (posx_q),
    .posy_i   (posy_q),
    .xmax_i   (xmax),
    .ymax_i   (ymax),
    .flagx_o  (flagx),
    .flagy_o  (flagy)
  );

  assign bus.posx      = posx_q;
  assign bus.posy      = posy_q;
  assign bus.flagx_out = flagx;
  assign bus.flagy_out = flagy;
  assign bus.flag_out  = flagx | flagy;
endmodule

// File: tb/tb_object_bounce_mover.sv
// Directed bench for object_bounce_mover: load, step latency, clamping,
// edge flags, corner hold and tick-held-through-reset.
module tb_object_bounce_mover;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  object_bounce_mover_if #(.VEL_W(4)) bus ();

  object_bounce_mover #(.SCREEN_W(640), .SCREEN_H(480), .VEL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reset with a new start position; returns #1 after the load edge.
  task automatic apply_reset(input logic [9:0] ix, input logic [8:0] iy);
    @(negedge clk);
    bus.moveclk  = 1'b0;
    bus.initPosX = ix;
    bus.initPosY = iy;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int hold);
    @(negedge clk);
    bus.moveclk = 1'b1;
    repeat (hold) @(negedge clk);
    bus.moveclk = 1'b0;
    repeat (hold) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.moveclk = 1'b0;
    bus.vx = 4'd0; bus.vy = 4'd0; bus.dx = 2'b00; bus.dy = 2'b00;
    bus.width = 10'd16; bus.height = 9'd16;
    bus.initPosX = 10'd100; bus.initPosY = 9'd50;
    repeat (4) @(negedge clk);
    n_cmp++; if (bus.posx !== 10'd0) begin n_bad++; $display("FAIL reset_posx: got %0d want 0", bus.posx); end
    n_cmp++; if (bus.posy !== 9'd0) begin n_bad++; $display("FAIL reset_posy: got %0d want 0", bus.posy); end
    n_cmp++; if (bus.flag_out !== 1'b0) begin n_bad++; $display("FAIL reset_flag: got %b want 0", bus.flag_out); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.posx !== 10'd100) begin n_bad++; $display("FAIL load_posx: got %0d want 100", bus.posx); end
    n_cmp++; if (bus.posy !== 9'd50) begin n_bad++; $display("FAIL load_posy: got %0d want 50", bus.posy); end
    n_cmp++; if (bus.flag_out !== 1'b0) begin n_bad++; $display("FAIL load_flag_e1: got %b want 0", bus.flag_out); end
    @(posedge clk); #1;
    n_cmp++; if ({bus.flag_out, bus.flagx_out, bus.flagy_out} !== 3'b000) begin
      n_bad++; $display("FAIL load_flags: got %b want 000", {bus.flag_out, bus.flagx_out, bus.flagy_out});
    end
  endtask

  task automatic test_step_latency;
    bus.dx = 2'b11; bus.vx = 4'd1; bus.dy = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.moveclk = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      n_cmp++; if (bus.posx !== 10'(100 + i)) begin n_bad++; $display("FAIL step_early_%0d: got %0d want %0d", i, bus.posx, 100 + i); end
      @(posedge clk); #1;
      n_cmp++; if (bus.posx !== 10'(101 + i)) begin n_bad++; $display("FAIL step_edge3_%0d: got %0d want %0d", i, bus.posx, 101 + i); end
      repeat (17) @(negedge clk);
      bus.moveclk = 1'b0;
      repeat (20) @(negedge clk);
    end
    n_cmp++; if (bus.posx !== 10'd105) begin n_bad++; $display("FAIL step_final_x: got %0d want 105", bus.posx); end
    n_cmp++; if (bus.posy !== 9'd50) begin n_bad++; $display("FAIL step_final_y: got %0d want 50", bus.posy); end
  endtask

  task automatic test_right_clamp;
    bus.width = 10'd16; bus.dx = 2'b11; bus.vx = 4'd4; bus.dy = 2'b00;
    apply_reset(10'd630, 9'd50);
    n_cmp++; if (bus.posx !== 10'd624) begin n_bad++; $display("FAIL load_clamp_x: got %0d want 624", bus.posx); end
    tick(6);
    n_cmp++; if (bus.posx !== 10'd624) begin n_bad++; $display("FAIL right_hold: got %0d want 624", bus.posx); end
    n_cmp++; if ({bus.flag_out, bus.flagx_out, bus.flagy_out} !== 3'b110) begin
      n_bad++; $display("FAIL right_flags_630: got %b want 110", {bus.flag_out, bus.flagx_out, bus.flagy_out});
    end
    apply_reset(10'd622, 9'd50);
    @(negedge clk);
    bus.moveclk = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (bus.posx !== 10'd624) begin n_bad++; $display("FAIL right_clamp: got %0d want 624", bus.posx); end
    n_cmp++; if (bus.flagx_out !== 1'b0) begin n_bad++; $display("FAIL flag_lag: got %b want 0", bus.flagx_out); end
    @(posedge clk); #1;
    n_cmp++; if ({bus.flag_out, bus.flagx_out, bus.flagy_out} !== 3'b110) begin
      n_bad++; $display("FAIL right_flags: got %b want 110", {bus.flag_out, bus.flagx_out, bus.flagy_out});
    end
    repeat (6) @(negedge clk);
    bus.moveclk = 1'b0;
    repeat (6) @(negedge clk);
    bus.dx = 2'b10;
    tick(6);
    n_cmp++; if (bus.posx !== 10'd620) begin n_bad++; $display("FAIL left_step: got %0d want 620", bus.posx); end
    n_cmp++; if (bus.flag_out !== 1'b0) begin n_bad++; $display("FAIL left_flag: got %b want 0", bus.flag_out); end
  endtask

  task automatic test_top_edge;
    bus.dx = 2'b00; bus.dy = 2'b10; bus.vy = 4'd3;
    apply_reset(10'd100, 9'd2);
    tick(6);
    n_cmp++; if (bus.posy !== 9'd0) begin n_bad++; $display("FAIL top_clamp: got %0d want 0", bus.posy); end
    n_cmp++; if ({bus.flagx_out, bus.flagy_out} !== 2'b01) begin n_bad++; $display("FAIL top_flags: got %b want 01", {bus.flagx_out, bus.flagy_out}); end
    bus.dy = 2'b11;
    tick(6);
    n_cmp++; if (bus.posy !== 9'd3) begin n_bad++; $display("FAIL down_step: got %0d want 3", bus.posy); end
    n_cmp++; if (bus.flagy_out !== 1'b0) begin n_bad++; $display("FAIL down_flag: got %b want 0", bus.flagy_out); end
  endtask

  task automatic test_corner_hold;
    bus.dx = 2'b01; bus.dy = 2'b01; bus.vx = 4'd5; bus.vy = 4'd5;
    apply_reset(10'd0, 9'd0);
    @(posedge clk); #1;
    n_cmp++; if ({bus.flagx_out, bus.flagy_out} !== 2'b11) begin n_bad++; $display("FAIL corner_flags: got %b want 11", {bus.flagx_out, bus.flagy_out}); end
    for (int i = 0; i < 10; i++) tick(4);
    n_cmp++; if (bus.posx !== 10'd0) begin n_bad++; $display("FAIL corner_x: got %0d want 0", bus.posx); end
    n_cmp++; if (bus.posy !== 9'd0) begin n_bad++; $display("FAIL corner_y: got %0d want 0", bus.posy); end
  endtask

  task automatic test_reset_moveclk;
    bus.dx = 2'b11; bus.vx = 4'd3; bus.dy = 2'b00;
    @(negedge clk);
    bus.initPosX = 10'd200; bus.initPosY = 9'd60;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.moveclk = ~bus.moveclk;
      repeat (2) @(negedge clk);
    end
    bus.moveclk = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++; if (bus.posx !== 10'd200) begin n_bad++; $display("FAIL held_tick_x: got %0d want 200", bus.posx); end
    n_cmp++; if (bus.posy !== 9'd60) begin n_bad++; $display("FAIL held_tick_y: got %0d want 60", bus.posy); end
    bus.moveclk = 1'b0;
    repeat (5) @(negedge clk);
    tick(6);
    n_cmp++; if (bus.posx !== 10'd203) begin n_bad++; $display("FAIL after_held_x: got %0d want 203", bus.posx); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_step_latency();
    test_right_clamp();
    test_top_edge();
    test_corner_hold();
    test_reset_moveclk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
